// File: rtl/glycemic_pkg.sv
// -----------------------------------------------------------------------------
// glycemic_pkg
// Shared definitions for the glycemic index monitor:
//   - alarm_state_t : alarm state machine encoding (NORMAL, HIGH, LOW)
//   - DEF_*         : default parameter values for the monitor
//   - extract_index : picks the index bits out of a window sum
// -----------------------------------------------------------------------------
package glycemic_pkg;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      HIGH   = 2'd1,
      LOW    = 2'd2
   } alarm_state_t;

   localparam int DEF_SENSOR_W  = 8;
   localparam int DEF_INDEX_W   = 4;
   localparam int DEF_LOG_DEPTH = 2;
   localparam int DEF_HIGH_TH   = 12;
   localparam int DEF_LOW_TH    = 3;
   localparam int DEF_HYST      = 2;
   localparam int DEF_PERSIST   = 3;

   // The average is sum >> log_depth (sensor_w bits wide) and the index is the
   // top index_w bits of that average, so both shifts fold into one. The sum
   // never exceeds 2^(sensor_w+log_depth)-1, so the result fits index_w bits.
   function automatic logic [31:0] extract_index(input logic [31:0] sum,
                                                 input int          sensor_w,
                                                 input int          index_w,
                                                 input int          log_depth);
      return sum >> (log_depth + sensor_w - index_w);
   endfunction

endpackage

// File: rtl/gi_window_avg.sv
// -----------------------------------------------------------------------------
// gi_window_avg
// Sliding-window moving average over the last 2^LOG_DEPTH accepted samples,
// producing a registered index and a one-cycle valid pulse once the window
// holds a full set of samples.
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         synchronous clear of window, sum, pointer, fill and index
//   sample_valid  sample carries a new value this cycle
//   sample        raw sensor sample (SENSOR_W)
//   index         registered index of the window average (INDEX_W)
//   index_valid   one-cycle pulse when index was updated from a full window
// -----------------------------------------------------------------------------
module gi_window_avg
   import glycemic_pkg::*;
#(
   parameter int SENSOR_W  = DEF_SENSOR_W,
   parameter int INDEX_W   = DEF_INDEX_W,
   parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                sample_valid,
   input  logic [SENSOR_W-1:0] sample,
   output logic [INDEX_W-1:0]  index,
   output logic                index_valid
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int SUM_W = SENSOR_W + LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] FILL_FULL = {1'b1, {LOG_DEPTH{1'b0}}};

   logic [SENSOR_W-1:0]  win_rd [DEPTH];
   logic [SENSOR_W-1:0]  evicted;
   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH:0]   fill_q, fill_d;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [INDEX_W-1:0]   index_q, index_d;
   logic                 index_valid_q, index_valid_d;

   // Window cells. They are cleared on reset/flush so that the entry being
   // evicted reads as zero until the window has filled once.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
      logic [SENSOR_W-1:0] cell_q, cell_d;

      always_comb begin
         cell_d = cell_q;
         if (flush) begin
            cell_d = '0;
         end else if (sample_valid && (wr_ptr_q == LOG_DEPTH'(gi))) begin
            cell_d = sample;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cell_q <= '0;
         end else begin
            cell_q <= cell_d;
         end
      end

      assign win_rd[gi] = cell_q;
   end

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      fill_d        = fill_q;
      sum_d         = sum_q;
      index_d       = index_q;
      index_valid_d = 1'b0;
      evicted       = win_rd[wr_ptr_q];

      if (flush) begin
         // flush takes priority; a sample presented in the same cycle is lost
         wr_ptr_d = '0;
         fill_d   = '0;
         sum_d    = '0;
         index_d  = '0;
      end else if (sample_valid) begin
         sum_d    = sum_q + SUM_W'(sample) - SUM_W'(evicted);
         wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + (LOG_DEPTH+1)'(1);
         end
         // index only tracks averages of a complete window
         if (fill_d == FILL_FULL) begin
            index_d       = INDEX_W'(extract_index(32'(sum_d), SENSOR_W, INDEX_W, LOG_DEPTH));
            index_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         fill_q        <= '0;
         sum_q         <= '0;
         index_q       <= '0;
         index_valid_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         fill_q        <= fill_d;
         sum_q         <= sum_d;
         index_q       <= index_d;
         index_valid_q <= index_valid_d;
      end
   end

   assign index       = index_q;
   assign index_valid = index_valid_q;

endmodule

// File: rtl/glycemic_index_monitor.sv
// -----------------------------------------------------------------------------
// glycemic_index_monitor
// Moving-average glycemic index over a stream of blood-sensor samples, with a
// high/low alarm state machine using persistence filtering and hysteresis.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear of window, index and alarm state
//   sampleValid    bloodSensor carries a new sample this cycle
//   bloodSensor    raw sensor sample (SENSOR_W)
//   glycemicIndex  registered index of the current window average (INDEX_W)
//   indexValid     one-cycle pulse: glycemicIndex updated from a full window
//   alarmHigh      high alarm active
//   alarmLow       low alarm active
// -----------------------------------------------------------------------------
module glycemic_index_monitor
   import glycemic_pkg::*;
#(
   parameter int SENSOR_W  = DEF_SENSOR_W,
   parameter int INDEX_W   = DEF_INDEX_W,
   parameter int LOG_DEPTH = DEF_LOG_DEPTH,
   parameter int HIGH_TH   = DEF_HIGH_TH,
   parameter int LOW_TH    = DEF_LOW_TH,
   parameter int HYST      = DEF_HYST,
   parameter int PERSIST   = DEF_PERSIST
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                sampleValid,
   input  logic [SENSOR_W-1:0] bloodSensor,
   output logic [INDEX_W-1:0]  glycemicIndex,
   output logic                indexValid,
   output logic                alarmHigh,
   output logic                alarmLow
);

   localparam int IDX_MAX = (1 << INDEX_W) - 1;

   if (!(LOW_TH < HIGH_TH) || !(HYST <= HIGH_TH) || !(LOW_TH + HYST <= IDX_MAX) ||
       !(HIGH_TH <= IDX_MAX) || !(PERSIST >= 1) || !(INDEX_W <= SENSOR_W)) begin : g_bad_params
      $error("glycemic_index_monitor: illegal parameter combination");
   end

   localparam int CNT_W = $clog2(PERSIST + 1);
   localparam logic [CNT_W-1:0]   PERSIST_C = CNT_W'(PERSIST);
   localparam logic [INDEX_W-1:0] HIGH_SET  = INDEX_W'(HIGH_TH);
   localparam logic [INDEX_W-1:0] LOW_SET   = INDEX_W'(LOW_TH);
   localparam logic [INDEX_W-1:0] HIGH_REL  = INDEX_W'(HIGH_TH - HYST);
   localparam logic [INDEX_W-1:0] LOW_REL   = INDEX_W'(LOW_TH + HYST);

   logic [INDEX_W-1:0] idx;
   logic               idx_valid;

   alarm_state_t     state_q, state_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
   logic             alarm_high_q, alarm_high_d;
   logic             alarm_low_q, alarm_low_d;

   gi_window_avg #(
      .SENSOR_W  (SENSOR_W),
      .INDEX_W   (INDEX_W),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_window (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .sample_valid (sampleValid),
      .sample       (bloodSensor),
      .index        (idx),
      .index_valid  (idx_valid)
   );

   // The FSM consumes the registered index, so alarms trail the sample by two
   // edges. It only advances on cycles carrying a fresh full-window index.
   always_comb begin
      state_d  = state_q;
      hi_cnt_d = hi_cnt_q;
      lo_cnt_d = lo_cnt_q;

      if (flush) begin
         state_d  = NORMAL;
         hi_cnt_d = '0;
         lo_cnt_d = '0;
      end else if (idx_valid) begin
         unique case (state_q)
            NORMAL: begin
               if (idx >= HIGH_SET) begin
                  hi_cnt_d = (hi_cnt_q == PERSIST_C) ? hi_cnt_q : hi_cnt_q + CNT_W'(1);
               end else begin
                  hi_cnt_d = '0;
               end
               if (idx <= LOW_SET) begin
                  lo_cnt_d = (lo_cnt_q == PERSIST_C) ? lo_cnt_q : lo_cnt_q + CNT_W'(1);
               end else begin
                  lo_cnt_d = '0;
               end
               if (hi_cnt_d == PERSIST_C) begin
                  state_d  = HIGH;
                  hi_cnt_d = '0;
                  lo_cnt_d = '0;
               end else if (lo_cnt_d == PERSIST_C) begin
                  state_d  = LOW;
                  hi_cnt_d = '0;
                  lo_cnt_d = '0;
               end
            end
            // Counters are already zero in the alarm states (cleared on entry).
            HIGH: begin
               if (idx <= HIGH_REL) state_d = NORMAL;
            end
            LOW: begin
               if (idx >= LOW_REL) state_d = NORMAL;
            end
            default: begin
               state_d  = NORMAL;
               hi_cnt_d = '0;
               lo_cnt_d = '0;
            end
         endcase
      end

      alarm_high_d = (state_d == HIGH);
      alarm_low_d  = (state_d == LOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= NORMAL;
         hi_cnt_q     <= '0;
         lo_cnt_q     <= '0;
         alarm_high_q <= 1'b0;
         alarm_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_cnt_q     <= hi_cnt_d;
         lo_cnt_q     <= lo_cnt_d;
         alarm_high_q <= alarm_high_d;
         alarm_low_q  <= alarm_low_d;
      end
   end

   assign glycemicIndex = idx;
   assign indexValid    = idx_valid;
   assign alarmHigh     = alarm_high_q;
   assign alarmLow      = alarm_low_q;

endmodule

// File: tb/tb_glycemic_index_monitor.sv
// -----------------------------------------------------------------------------
// tb_glycemic_index_monitor
// Directed sequence with hand-computed expectations: reset, window fill and
// slide, high alarm with hysteresis, low alarm with an interrupted streak,
// flush with a coincident sample, and an asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_glycemic_index_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       sampleValid;
   logic [7:0] bloodSensor;
   logic [3:0] glycemicIndex;
   logic       indexValid;
   logic       alarmHigh;
   logic       alarmLow;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   glycemic_index_monitor #(
      .SENSOR_W  (8),
      .INDEX_W   (4),
      .LOG_DEPTH (2),
      .HIGH_TH   (12),
      .LOW_TH    (3),
      .HYST      (2),
      .PERSIST   (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .sampleValid   (sampleValid),
      .bloodSensor   (bloodSensor),
      .glycemicIndex (glycemicIndex),
      .indexValid    (indexValid),
      .alarmHigh     (alarmHigh),
      .alarmLow      (alarmLow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] idx, input logic vld,
                          input logic hi, input logic lo);
      chk({tag, ".idx"},   32'(glycemicIndex), 32'(idx));
      chk({tag, ".valid"}, 32'(indexValid),    32'(vld));
      chk({tag, ".high"},  32'(alarmHigh),     32'(hi));
      chk({tag, ".low"},   32'(alarmLow),      32'(lo));
   endtask

   task automatic send(input logic [7:0] v);
      @(negedge clk);
      sampleValid = 1'b1;
      bloodSensor = v;
      @(posedge clk);
      #1;
      sampleValid = 1'b0;
      $display("sample=%02h idx=%0h valid=%0b high=%0b low=%0b",
               v, glycemicIndex, indexValid, alarmHigh, alarmLow);
   endtask

   task automatic idle();
      @(negedge clk);
      sampleValid = 1'b0;
      @(posedge clk);
      #1;
      $display("idle       idx=%0h valid=%0b high=%0b low=%0b",
               glycemicIndex, indexValid, alarmHigh, alarmLow);
   endtask

   initial begin
      rst_n       = 1'b0;
      flush       = 1'b0;
      sampleValid = 1'b0;
      bloodSensor = 8'h00;

      // ---- reset values
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("reset.sum", 32'(dut.u_window.sum_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- fill: index only after the 4th sample
      send(8'hEE); chk_out("fill1", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h7C); chk_out("fill2", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h9D); chk_out("fill3", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'hF8); chk_out("fill4", 4'hB, 1'b1, 1'b0, 1'b0);
      chk("fill4.sum", 32'(dut.u_window.sum_q), 32'd767);

      // ---- slide: 0x30 evicts 0xEE
      send(8'h30); chk_out("slide", 4'h9, 1'b1, 1'b0, 1'b0);
      chk("slide.sum", 32'(dut.u_window.sum_q), 32'd577);
      chk("slide.wrptr", 32'(dut.u_window.wr_ptr_q), 32'd1);
      idle();      chk_out("hold", 4'h9, 1'b0, 1'b0, 1'b0);

      // ---- plain flush
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk_out("flush", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("flush.sum", 32'(dut.u_window.sum_q), 32'd0);

      // ---- high alarm: three index-15 results, then release at index 9
      send(8'hFF); chk_out("hi1", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'hFF); chk_out("hi2", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'hFF); chk_out("hi3", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'hFF); chk_out("hi4", 4'hF, 1'b1, 1'b0, 1'b0);
      send(8'hFF); chk_out("hi5", 4'hF, 1'b1, 1'b0, 1'b0);
      send(8'hFF); chk_out("hi6", 4'hF, 1'b1, 1'b0, 1'b0);
      send(8'h80); chk_out("hi7", 4'hD, 1'b1, 1'b1, 1'b0);
      send(8'h80); chk_out("hi8", 4'hB, 1'b1, 1'b1, 1'b0);
      send(8'h80); chk_out("hi9", 4'h9, 1'b1, 1'b1, 1'b0);
      idle();      chk_out("hi_rel", 4'h9, 1'b0, 1'b0, 1'b0);

      // ---- low alarm: streak of 2 broken by index 4, then 3 in a row
      send(8'h10); chk_out("lo1", 4'h6, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo2", 4'h4, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo3", 4'h2, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo4", 4'h1, 1'b1, 1'b0, 1'b0);
      send(8'hF0); chk_out("lo5", 4'h4, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo6", 4'h4, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo7", 4'h4, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo8", 4'h4, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo9", 4'h1, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo10", 4'h1, 1'b1, 1'b0, 1'b0);
      send(8'h10); chk_out("lo11", 4'h1, 1'b1, 1'b0, 1'b0);
      idle();      chk_out("lo_set", 4'h1, 1'b0, 1'b0, 1'b1);

      // ---- flush with a coincident sample: sample dropped, alarm cleared
      @(negedge clk);
      flush       = 1'b1;
      sampleValid = 1'b1;
      bloodSensor = 8'hFF;
      @(posedge clk);
      #1;
      flush       = 1'b0;
      sampleValid = 1'b0;
      chk_out("flush_drop", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("flush_drop.sum", 32'(dut.u_window.sum_q), 32'd0);
      send(8'h40); chk_out("refill1", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h40); chk_out("refill2", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h40); chk_out("refill3", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h40); chk_out("refill4", 4'h4, 1'b1, 1'b0, 1'b0);

      // ---- asynchronous reset between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
      chk("async_rst.sum", 32'(dut.u_window.sum_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h40); chk_out("post_rst1", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h40); chk_out("post_rst2", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h40); chk_out("post_rst3", 4'h0, 1'b0, 1'b0, 1'b0);
      send(8'h40); chk_out("post_rst4", 4'h4, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
